// File: rtl/majority_response_checker.sv
// Response checker for a 4-input majority circuit. It takes vectors over a valid/ready
// handshake, drives each one to the DUT, samples the DUT output after a settle delay and
// tallies the mismatches.
module majority_response_checker #(
    parameter int SETTLE  = 4,
    parameter int NUM_VEC = 16,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          vec_valid,
    input  logic [3:0]    vec,
    output logic          vec_ready,
    output logic [3:0]    vec_drive,
    input  logic          dut_f,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [CW-1:0] chk_cnt,
    output logic [CW-1:0] err_cnt,
    output logic [3:0]    first_err_vec,
    output logic          first_err_valid
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [3:0]    vec_drive_q, vec_drive_d;
    logic [CW-1:0] chk_cnt_q, chk_cnt_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;
    logic [3:0]    first_err_vec_q, first_err_vec_d;
    logic          first_err_valid_q, first_err_valid_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic          exp_s;

    function automatic logic maj4(input logic [3:0] v);
        logic [2:0] ones;
        ones = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
        return (ones >= 3'd3);
    endfunction

    // Golden value uses only the held vector, never the live input.
    assign exp_s = maj4(vec_drive_q);

    // Next-state logic and counter/capture updates.
    always_comb begin
        state_d           = state_q;
        settle_d          = settle_q;
        vec_drive_d       = vec_drive_q;
        chk_cnt_d         = chk_cnt_q;
        err_cnt_d         = err_cnt_q;
        first_err_vec_d   = first_err_vec_q;
        first_err_valid_d = first_err_valid_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d           = S_ACCEPT;
                    chk_cnt_d         = {CW{1'b0}};
                    err_cnt_d         = {CW{1'b0}};
                    first_err_vec_d   = 4'b0000;
                    first_err_valid_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_ACCEPT: begin
                if (vec_valid) begin
                    vec_drive_d = vec;
                    settle_d    = SW'(SETTLE - 1);
                    state_d     = S_SETTLE;
                end else begin
                    state_d = S_ACCEPT;
                end
            end
            S_SETTLE: begin
                if (settle_q == {SW{1'b0}}) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            S_SAMPLE: begin
                chk_cnt_d = chk_cnt_q + CW'(1);
                if (dut_f != exp_s) begin
                    if (err_cnt_q != {CW{1'b1}}) begin
                        err_cnt_d = err_cnt_q + CW'(1);
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                    if (!first_err_valid_q) begin
                        first_err_vec_d   = vec_drive_q;
                        first_err_valid_d = 1'b1;
                    end else begin
                        first_err_valid_d = first_err_valid_q;
                    end
                end else begin
                    err_cnt_d = err_cnt_q;
                end
                if (chk_cnt_d == CW'(NUM_VEC)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ACCEPT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs are decoded from the next state so they come straight from flops.
    always_comb begin
        ready_d = (state_d == S_ACCEPT);
        busy_d  = (state_d == S_ACCEPT) || (state_d == S_SETTLE) || (state_d == S_SAMPLE);
        done_d  = (state_d == S_DONE);
        pass_d  = (state_d == S_DONE) && (err_cnt_d == {CW{1'b0}});
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= S_IDLE;
            settle_q          <= {SW{1'b0}};
            vec_drive_q       <= 4'b0000;
            chk_cnt_q         <= {CW{1'b0}};
            err_cnt_q         <= {CW{1'b0}};
            first_err_vec_q   <= 4'b0000;
            first_err_valid_q <= 1'b0;
            ready_q           <= 1'b0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            settle_q          <= settle_d;
            vec_drive_q       <= vec_drive_d;
            chk_cnt_q         <= chk_cnt_d;
            err_cnt_q         <= err_cnt_d;
            first_err_vec_q   <= first_err_vec_d;
            first_err_valid_q <= first_err_valid_d;
            ready_q           <= ready_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            pass_q            <= pass_d;
        end
    end

    assign vec_ready       = ready_q;
    assign vec_drive       = vec_drive_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign chk_cnt         = chk_cnt_q;
    assign err_cnt         = err_cnt_q;
    assign first_err_vec   = first_err_vec_q;
    assign first_err_valid = first_err_valid_q;

endmodule

// File: tb/tb_majority_response_checker.sv
// Directed bench for majority_response_checker: a DUT model (correct, stuck-at-0 or delayed)
// sits behind vec_drive, and the results are checked against hand-computed values.
module tb_majority_response_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       vec_valid = 1'b0;
    logic [3:0] vec = 4'b0000;
    logic       vec_ready;
    logic [3:0] vec_drive;
    logic       dut_f;
    logic       busy, done, pass;
    logic [7:0] chk_cnt, err_cnt;
    logic [3:0] first_err_vec;
    logic       first_err_valid;

    int         n_total = 0;
    int         n_bad   = 0;
    int         dut_mode = 0;  // 0 correct, 1 stuck-at-0, 2 delayed
    int         dut_dly  = 4;
    logic [7:0] pipe;

    majority_response_checker #(.SETTLE(4), .NUM_VEC(16), .CW(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec(vec),
        .vec_ready(vec_ready), .vec_drive(vec_drive), .dut_f(dut_f), .busy(busy),
        .done(done), .pass(pass), .chk_cnt(chk_cnt), .err_cnt(err_cnt),
        .first_err_vec(first_err_vec), .first_err_valid(first_err_valid)
    );

    always #5 clk = ~clk;

    function automatic logic ref_maj(input logic [3:0] v);
        return (v == 4'b0111) || (v == 4'b1011) || (v == 4'b1101) ||
               (v == 4'b1110) || (v == 4'b1111);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) pipe <= 8'h00;
        else     pipe <= {pipe[6:0], ref_maj(vec_drive)};
    end

    always_comb begin
        dut_f = ref_maj(vec_drive);
        if (dut_mode == 1)      dut_f = 1'b0;
        else if (dut_mode == 2) dut_f = pipe[dut_dly-1];
        else                    dut_f = ref_maj(vec_drive);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(posedge clk) #1 rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
    endtask

    // Wait for ready, optionally idle with valid low for gap cycles, then hand over v.
    task automatic send(input logic [3:0] v, input int gap);
        int         n;
        logic [7:0] cnt0;
        vec_valid = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (vec_ready) break;
            n++;
            if (n > 50) begin
                check("ready_timeout", 32'd0, 32'd1);
                return;
            end
        end
        cnt0 = chk_cnt;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check("gap_ready", {31'd0, vec_ready}, 32'd1);
            check("gap_cnt", {24'd0, chk_cnt}, {24'd0, cnt0});
        end
        vec = v;
        vec_valid = 1'b1;
        @(posedge clk) #1 vec_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            n++;
            if (n > 50) begin
                check("done_timeout", 32'd0, 32'd1);
                return;
            end
        end
    endtask

    task automatic full_run(input int gap);
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = i[3:0];
            send(v, gap);
        end
        wait_done();
    endtask

    task automatic check_final(input string tag, input int exp_err, input logic exp_fev,
                               input logic [3:0] exp_vec);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_ready"}, {31'd0, vec_ready}, 32'd0);
        check({tag, "_chk"}, {24'd0, chk_cnt}, 32'd16);
        check({tag, "_err"}, {24'd0, err_cnt}, exp_err);
        check({tag, "_pass"}, {31'd0, pass}, (exp_err == 0) ? 32'd1 : 32'd0);
        check({tag, "_fev"}, {31'd0, first_err_valid}, {31'd0, exp_fev});
        check({tag, "_fvec"}, {28'd0, first_err_vec}, {28'd0, exp_vec});
        check({tag, "_drive"}, {28'd0, vec_drive}, 32'hF);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_pass"}, {31'd0, pass}, 32'd0);
        check({tag, "_ready"}, {31'd0, vec_ready}, 32'd0);
        check({tag, "_drive"}, {28'd0, vec_drive}, 32'd0);
        check({tag, "_chk"}, {24'd0, chk_cnt}, 32'd0);
        check({tag, "_err"}, {24'd0, err_cnt}, 32'd0);
        check({tag, "_fev"}, {31'd0, first_err_valid}, 32'd0);
        check({tag, "_fvec"}, {28'd0, first_err_vec}, 32'd0);
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        check_zero("rst");

        dut_mode = 0;
        full_run(0);
        check_final("good", 0, 1'b0, 4'b0000);

        dut_mode = 1;
        full_run(0);
        check_final("stuck0", 5, 1'b1, 4'b0111);

        dut_mode = 0;
        full_run(3);
        check_final("gaps", 0, 1'b0, 4'b0000);

        // Delay sweep: a delay equal to SETTLE is absorbed; SETTLE+2 makes each sample see
        // the previous vector, so 7,8,11,12,13 miscompare.
        do_reset();
        dut_mode = 2;
        dut_dly  = 4;
        full_run(0);
        check_final("dly4", 0, 1'b0, 4'b0000);
        do_reset();
        dut_dly = 6;
        full_run(0);
        check_final("dly6", 5, 1'b1, 4'b0111);

        // Reset in SETTLE after five checks (stuck DUT, so errors are on record).
        do_reset();
        dut_mode = 1;
        pulse_start();
        for (int i = 7; i < 13; i++) begin
            logic [3:0] v;
            v = i[3:0];
            send(v, 0);
        end
        check("pre_rst_chk", {24'd0, chk_cnt}, 32'd5);
        check("pre_rst_err", {24'd0, err_cnt}, 32'd2);
        do_reset();
        check_zero("mid_rst");
        dut_mode = 0;
        full_run(0);
        check_final("after_rst", 0, 1'b0, 4'b0000);

        // start mid-run is ignored; start in DONE restarts.
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            logic [3:0] v;
            v = i[3:0];
            send(v, 0);
        end
        pulse_start();
        check("mid_start_busy", {31'd0, busy}, 32'd1);
        check("mid_start_chk", {24'd0, chk_cnt}, 32'd2);
        for (int i = 3; i < 16; i++) begin
            logic [3:0] v;
            v = i[3:0];
            send(v, 0);
        end
        wait_done();
        check_final("mid_start", 0, 1'b0, 4'b0000);
        pulse_start();
        check("restart_done", {31'd0, done}, 32'd0);
        check("restart_chk", {24'd0, chk_cnt}, 32'd0);
        check("restart_err", {24'd0, err_cnt}, 32'd0);
        check("restart_ready", {31'd0, vec_ready}, 32'd1);
        check("restart_busy", {31'd0, busy}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
